two_pulses_gen: RTL

TWO_PULSES_GEN -- requirements
Module: two_pulses_gen

---
 rtl/two_pulses_pkg.sv | 15 +
 rtl/two_pulses_gen_if.sv | 26 ++
 rtl/pulse_gap_cnt.sv | 25 ++
 rtl/two_pulses_gen.sv | 137 +++++++++++++
 4 files changed

// File: rtl/two_pulses_pkg.sv
// Shared types and default widths for the two-pulse detector stimulus generator.
package two_pulses_pkg;
    localparam int DEF_CNT_W = 3;
    localparam int DEF_GAP_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        GAP,
        YP,
        TRAIL,
        HOLD,
        TERM
    } state_t;
endpackage

// File: rtl/two_pulses_gen_if.sv
// Request, configuration, detector response and pulse outputs of two_pulses_gen.
interface two_pulses_gen_if #(
    parameter int CNT_W = two_pulses_pkg::DEF_CNT_W,
    parameter int GAP_W = two_pulses_pkg::DEF_GAP_W
) ();
    logic             start_i;
    logic [CNT_W-1:0] ycnt_i;
    logic [GAP_W-1:0] gap_i;
    logic [GAP_W-1:0] hold_i;
    logic             p_i;
    logic             x_o;
    logic             y_o;
    logic             busy_o;
    logic             done_o;
    logic             pass_o;

    modport master (
        output start_i, ycnt_i, gap_i, hold_i, p_i,
        input  x_o, y_o, busy_o, done_o, pass_o
    );

    modport slave (
        input  start_i, ycnt_i, gap_i, hold_i, p_i,
        output x_o, y_o, busy_o, done_o, pass_o
    );
endinterface

// File: rtl/pulse_gap_cnt.sv
// Loadable down-counter that stops at zero and flags it.
module pulse_gap_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/two_pulses_gen.sv
// Emits x, y^n, x, y pulse trains to a detector and checks its p response.
// state | meaning
// IDLE  | waiting for start_i; also the cycle carrying done_o
// LEAD  | leading x pulse
// GAP   | gap cycles before a y pulse or before the trailing x
// YP    | one y pulse
// TRAIL | trailing x pulse, p must equal exp
// HOLD  | hold cycles, p must equal exp
// TERM  | terminating y pulse, p must be 0
module two_pulses_gen
    import two_pulses_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP_W = DEF_GAP_W
) (
    input logic             clk,
    input logic             reset,
    two_pulses_gen_if.slave bus
);
    state_t           state, state_nx;
    logic [GAP_W-1:0] gap_r, hold_r;
    logic             exp_r, error_q, done_q;
    logic             accept, err_set;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [GAP_W-1:0] tmr_val;
    logic             ycnt_dec, ycnt_zero;

    pulse_gap_cnt #(.W(GAP_W)) u_tmr (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Remaining y pulses; decremented on the way into each YP.
    pulse_gap_cnt #(.W(CNT_W)) u_ycnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (bus.ycnt_i),
        .dec      (ycnt_dec),
        .zero     (ycnt_zero)
    );

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        err_set  = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = gap_r - GAP_W'(1);
        ycnt_dec = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start_i) begin
                    accept   = 1'b1;
                    state_nx = LEAD;
                end
            end
            LEAD, YP: begin
                if (gap_r != '0) begin
                    tmr_load = 1'b1;
                    state_nx = GAP;
                end else if (!ycnt_zero) begin
                    ycnt_dec = 1'b1;
                    state_nx = YP;
                end else begin
                    state_nx = TRAIL;
                end
            end
            GAP: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (!ycnt_zero) begin
                    ycnt_dec = 1'b1;
                    state_nx = YP;
                end else begin
                    state_nx = TRAIL;
                end
            end
            TRAIL: begin
                err_set = (bus.p_i != exp_r);
                if (hold_r != '0) begin
                    tmr_load = 1'b1;
                    tmr_val  = hold_r - GAP_W'(1);
                    state_nx = HOLD;
                end else begin
                    state_nx = TERM;
                end
            end
            HOLD: begin
                err_set = (bus.p_i != exp_r);
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    state_nx = TERM;
                end
            end
            TERM: begin
                err_set  = bus.p_i;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gap_r   <= '0;
            hold_r  <= '0;
            exp_r   <= 1'b0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= (state == TERM);
            if (accept) begin
                gap_r   <= bus.gap_i;
                hold_r  <= bus.hold_i;
                exp_r   <= (bus.ycnt_i == CNT_W'(2));
                error_q <= 1'b0;
            end else if (err_set) begin
                error_q <= 1'b1;
            end
        end
    end

    // busy also covers the done cycle, giving 4 + ycnt*(gap+1) + gap + hold cycles.
    assign bus.x_o    = (state == LEAD) || (state == TRAIL);
    assign bus.y_o    = (state == YP) || (state == TERM);
    assign bus.busy_o = (state != IDLE) || done_q;
    assign bus.done_o = done_q;
    assign bus.pass_o = done_q && !error_q;
endmodule
